// File: rtl/ode_sub_pkg.sv
// rtl/ode_sub_pkg.sv - shared constants and types for the ODE subtractor/monitor stages
package ode_sub_pkg;

    localparam int WIDTH_DEF = 16;
    localparam logic [WIDTH_DEF-1:0] SAT_MAX = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/abs_sat.sv
// rtl/abs_sat.sv - saturating absolute value of a two's complement difference
module abs_sat
    import ode_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] diff,
    input  logic             ovf,
    output logic [WIDTH-1:0] abs_out
);

    localparam logic [WIDTH-1:0] SAT      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // The most negative code has no positive twin, so it pins to the largest magnitude.
    always_comb begin
        abs_out = diff;
        if (ovf || (diff == MOST_NEG)) begin
            abs_out = SAT;
        end else if (diff[WIDTH-1]) begin
            abs_out = '0 - diff;
        end
    end

endmodule

// File: rtl/diff_convergence_monitor.sv
// rtl/diff_convergence_monitor.sv - per-vector max|diff| vs tolerance convergence verdict
// Optional macro FAIL_INDEX_EN adds fail_idx/fail_hit outputs.
module diff_convergence_monitor
    import ode_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [WIDTH-1:0] tol,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] diff,
    input  logic             diff_ovf,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic [WIDTH-1:0] max_abs,
`ifdef FAIL_INDEX_EN
    output logic [LEN_W-1:0] fail_idx,
    output logic             fail_hit,
`endif
    output logic             ovf_seen
);

    localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};

    mon_state_t       state_q, state_d;
    logic [LEN_W-1:0] vec_len_q, vec_len_d;
    logic [WIDTH-1:0] tol_q, tol_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] abs_q, abs_d;
    logic             abs_vld_q, abs_vld_d;
    logic             abs_ovf_q, abs_ovf_d;
    logic [WIDTH-1:0] max_abs_q, max_abs_d;
    logic             ovf_seen_q, ovf_seen_d;
    logic             done_q, done_d;
    logic             converged_q, converged_d;
`ifdef FAIL_INDEX_EN
    logic [LEN_W-1:0] abs_idx_q, abs_idx_d;
    logic [LEN_W-1:0] fail_idx_q, fail_idx_d;
    logic             fail_hit_q, fail_hit_d;
`endif

    logic [WIDTH-1:0] abs_w;
    logic [WIDTH-1:0] max_new;
    logic             ovf_new;
    logic             xfer;

    abs_sat #(.WIDTH(WIDTH)) u_abs_sat (
        .diff    (diff),
        .ovf     (diff_ovf),
        .abs_out (abs_w)
    );

    always_comb begin
        state_d     = state_q;
        vec_len_d   = vec_len_q;
        tol_d       = tol_q;
        count_d     = count_q;
        done_d      = 1'b0;
        converged_d = converged_q;

        xfer      = (state_q == RUN) && in_valid;
        abs_vld_d = xfer;
        abs_ovf_d = xfer && diff_ovf;
        abs_d     = abs_w;

        // Accumulate the element registered by the abs stage on the previous cycle.
        max_new = max_abs_q;
        ovf_new = ovf_seen_q;
        if (abs_vld_q) begin
            if (abs_q > max_abs_q) begin
                max_new = abs_q;
            end
            if (abs_ovf_q) begin
                ovf_new = 1'b1;
            end
        end
        max_abs_d  = max_new;
        ovf_seen_d = ovf_new;

`ifdef FAIL_INDEX_EN
        abs_idx_d  = count_q;
        fail_idx_d = fail_idx_q;
        fail_hit_d = fail_hit_q;
        if (abs_vld_q && !fail_hit_q && ((abs_q > tol_q) || abs_ovf_q)) begin
            fail_hit_d = 1'b1;
            fail_idx_d = abs_idx_q;
        end
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_len_d   = vec_len;
                    tol_d       = tol;
                    count_d     = '0;
                    max_abs_d   = '0;
                    ovf_seen_d  = 1'b0;
                    converged_d = 1'b0;
                    abs_vld_d   = 1'b0;
`ifdef FAIL_INDEX_EN
                    fail_idx_d  = '0;
                    fail_hit_d  = 1'b0;
`endif
                    if (vec_len == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        converged_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    count_d = count_q + ONE_LEN;
                    if ((count_q + ONE_LEN) == vec_len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d     = DONE;
                done_d      = 1'b1;
                converged_d = (max_new <= tol_q) && !ovf_new;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_len_q   <= '0;
            tol_q       <= '0;
            count_q     <= '0;
            abs_q       <= '0;
            abs_vld_q   <= 1'b0;
            abs_ovf_q   <= 1'b0;
            max_abs_q   <= '0;
            ovf_seen_q  <= 1'b0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
`ifdef FAIL_INDEX_EN
            abs_idx_q   <= '0;
            fail_idx_q  <= '0;
            fail_hit_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            vec_len_q   <= vec_len_d;
            tol_q       <= tol_d;
            count_q     <= count_d;
            abs_q       <= abs_d;
            abs_vld_q   <= abs_vld_d;
            abs_ovf_q   <= abs_ovf_d;
            max_abs_q   <= max_abs_d;
            ovf_seen_q  <= ovf_seen_d;
            done_q      <= done_d;
            converged_q <= converged_d;
`ifdef FAIL_INDEX_EN
            abs_idx_q   <= abs_idx_d;
            fail_idx_q  <= fail_idx_d;
            fail_hit_q  <= fail_hit_d;
`endif
        end
    end

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = done_q;
    assign converged = converged_q;
    assign max_abs   = max_abs_q;
    assign ovf_seen  = ovf_seen_q;
`ifdef FAIL_INDEX_EN
    assign fail_idx  = fail_idx_q;
    assign fail_hit  = fail_hit_q;
`endif

endmodule
